// File: rtl/postfix_sequencer.sv
// Issue stage for a stack-based ALU: consumes postfix tokens, issues one ALU op at a time,
// tracks stack depth to catch malformed expressions, and returns the final value.
//
// Handshakes: a token moves on any rising edge where tok_valid & tok_ready, a result moves on
// any rising edge where res_valid & res_ready; a raised res_valid stays up with res_* stable
// until it is taken.
module postfix_sequencer #(
  parameter int n           = 32,
  parameter int STACK_DEPTH = 8,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic [1:0]    tok_kind,
  input  logic [n-1:0]  tok_data,
  output logic [2:0]    alu_opcode,
  output logic [n-1:0]  alu_data,
  input  logic [n-1:0]  alu_result,
  input  logic          alu_overflow,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [n-1:0]  res_data,
  output logic          res_overflow,
  output logic          res_error,
  output logic [2:0]    dbg_state,
  output logic [DW-1:0] dbg_depth
);

  typedef enum logic [2:0] {
    S_ACCEPT = 3'd0,
    S_EXEC   = 3'd1,
    S_CHECK  = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] K_OPND = 2'b00;
  localparam logic [1:0] K_ADD  = 2'b01;
  localparam logic [1:0] K_MUL  = 2'b10;
  localparam logic [1:0] K_END  = 2'b11;

  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);
  localparam logic [DW-1:0] ONE       = DW'(1);
  localparam logic [DW-1:0] TWO       = DW'(2);

  state_t        state, state_d;
  logic [DW-1:0] depth, depth_d;
  logic          err, err_d;
  logic          ovf, ovf_d;
  logic [2:0]    op_q, op_d;
  logic [n-1:0]  data_q, data_d;
  logic [n-1:0]  res_data_d;
  logic          res_overflow_d, res_error_d;
  logic          tok_bad;

  assign dbg_state = state;
  assign dbg_depth = depth;

  always_comb begin
    tok_bad = 1'b0;
    case (tok_kind)
      K_OPND:        tok_bad = (depth == DEPTH_MAX);
      K_ADD, K_MUL:  tok_bad = (depth < TWO);
      default:       tok_bad = (depth != ONE);
    endcase
  end

  always_comb begin
    state_d        = state;
    depth_d        = depth;
    err_d          = err;
    ovf_d          = ovf;
    op_d           = op_q;
    data_d         = data_q;
    res_data_d     = res_data;
    res_overflow_d = res_overflow;
    res_error_d    = res_error;
    tok_ready      = 1'b0;
    alu_opcode     = OP_NOP;
    alu_data       = '0;
    res_valid      = 1'b0;

    case (state)
      S_ACCEPT: begin
        tok_ready = !RST;
        if (tok_valid && tok_ready) begin
          // Once an expression is poisoned, everything up to its end token is dropped.
          if (err) begin
            if (tok_kind == K_END) state_d = S_DRAIN;
          end else if (tok_bad) begin
            err_d = 1'b1;
            if (tok_kind == K_END) state_d = S_DRAIN;
          end else begin
            case (tok_kind)
              K_OPND:  op_d = OP_PUSH;
              K_ADD:   op_d = OP_ADD;
              K_MUL:   op_d = OP_MUL;
              default: op_d = OP_POP;
            endcase
            data_d  = tok_data;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        alu_opcode = op_q;
        if (op_q == OP_PUSH) begin
          alu_data = data_q;
          depth_d  = depth + ONE;
          state_d  = S_ACCEPT;
        end else begin
          depth_d  = depth - ONE;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        // ALU outputs for the op issued in EXEC are settled now.
        if (op_q == OP_POP) begin
          res_data_d     = alu_result;
          res_overflow_d = ovf;
          res_error_d    = 1'b0;
          state_d        = S_OUT;
        end else begin
          ovf_d   = ovf | alu_overflow;
          state_d = S_ACCEPT;
        end
      end
      S_DRAIN: begin
        if (depth != '0) begin
          alu_opcode = OP_POP;
          depth_d    = depth - ONE;
        end else begin
          res_data_d     = '0;
          res_overflow_d = ovf;
          res_error_d    = 1'b1;
          state_d        = S_OUT;
        end
      end
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_ACCEPT;
        end
      end
      default: state_d = S_ACCEPT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_ACCEPT;
      depth        <= '0;
      err          <= 1'b0;
      ovf          <= 1'b0;
      op_q         <= OP_NOP;
      data_q       <= '0;
      res_data     <= '0;
      res_overflow <= 1'b0;
      res_error    <= 1'b0;
    end else begin
      state        <= state_d;
      depth        <= depth_d;
      err          <= err_d;
      ovf          <= ovf_d;
      op_q         <= op_d;
      data_q       <= data_d;
      res_data     <= res_data_d;
      res_overflow <= res_overflow_d;
      res_error    <= res_error_d;
    end
  end

endmodule

// File: tb/tb_postfix_sequencer.sv
// Bench for postfix_sequencer: behavioural ALU stack, expression-level reference model,
// expected ALU op queue, directed plus random expressions.
module tb_postfix_sequencer;
  localparam int N  = 32;
  localparam int SD = 8;
  localparam int DW = $clog2(SD + 1);
  localparam int EW = N + 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          tok_valid;
  logic          tok_ready;
  logic [1:0]    tok_kind;
  logic [N-1:0]  tok_data;
  logic [2:0]    alu_opcode;
  logic [N-1:0]  alu_data;
  logic [N-1:0]  alu_result = '0;
  logic          alu_overflow = 1'b0;
  logic          res_valid;
  logic          res_ready;
  logic [N-1:0]  res_data;
  logic          res_overflow;
  logic          res_error;
  logic [2:0]    dbg_state;
  logic [DW-1:0] dbg_depth;

  postfix_sequencer #(.n(N), .STACK_DEPTH(SD)) dut (
    .CLK(CLK), .RST(RST),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_data(tok_data),
    .alu_opcode(alu_opcode), .alu_data(alu_data),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_overflow(res_overflow), .res_error(res_error),
    .dbg_state(dbg_state), .dbg_depth(dbg_depth)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- arithmetic shared by ALU model and reference ----------------
  function automatic void arith(input logic [1:0] k, input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] r, output logic o);
    longint sa, sb, v, maxv, minv;
    sa   = longint'(signed'(a));
    sb   = longint'(signed'(b));
    v    = (k == 2'b01) ? (sa + sb) : (sa * sb);
    maxv = (longint'(1) << 31) - 1;
    minv = -(longint'(1) << 31);
    r    = v[N-1:0];
    o    = (v > maxv) || (v < minv);
  endfunction

  // ---------------- behavioural ALU (no reset) ----------------
  logic [N-1:0] alu_stk[$];
  logic [2:0]   cap_op = 3'b000;
  logic [N-1:0] cap_data = '0;
  logic [N-1:0] alu_a, alu_b, alu_r;
  logic         alu_o;

  always @(negedge CLK) begin
    cap_op   <= alu_opcode;
    cap_data <= alu_data;
  end

  always @(posedge CLK) begin
    case (cap_op)
      3'b110: alu_stk.push_back(cap_data);
      3'b100, 3'b101: begin
        if (alu_stk.size() >= 2) begin
          alu_b = alu_stk.pop_back();
          alu_a = alu_stk.pop_back();
          arith((cap_op == 3'b100) ? 2'b01 : 2'b10, alu_a, alu_b, alu_r, alu_o);
          alu_stk.push_back(alu_r);
          alu_result   <= alu_r;
          alu_overflow <= alu_o;
        end
      end
      3'b111: if (alu_stk.size() > 0) alu_result <= alu_stk.pop_back();
      default: ;
    endcase
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int fails  = 0;
  logic [EW-1:0] exp_q[$];
  logic [1:0]    tk[$];
  logic [N-1:0]  td[$];
  logic [N-1:0]  e_r;
  logic          e_ro, e_re;
  int            e_lat;

  logic          s_tok_ready, s_res_valid, s_res_ovf, s_res_err;
  logic [2:0]    s_op;
  logic [N-1:0]  s_data, s_res_data;
  logic [DW-1:0] s_depth;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample mid-cycle, check any ALU op against the expected queue, then advance.
  task automatic tick();
    logic [EW-1:0] e;
    @(negedge CLK);
    s_tok_ready = tok_ready;
    s_op        = alu_opcode;
    s_data      = alu_data;
    s_res_valid = res_valid;
    s_res_data  = res_data;
    s_res_ovf   = res_overflow;
    s_res_err   = res_error;
    s_depth     = dbg_depth;
    if (alu_opcode !== 3'b000) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("alu_op", {alu_opcode, alu_data}, e);
    end
    @(posedge CLK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_tok(input logic [1:0] k, input logic [N-1:0] d);
    bit hs = 0;
    tok_valid = 1'b1;
    tok_kind  = k;
    tok_data  = d;
    for (int i = 0; i < 50 && !hs; i++) begin
      tick();
      hs = s_tok_ready;
    end
    if (!hs) check("tok_timeout", 0, 1);
    tok_valid = 1'b0;
    tok_data  = $urandom;
  endtask

  task automatic clear_toks();
    tk.delete();
    td.delete();
  endtask

  task automatic add_tok(input logic [1:0] k, input logic [N-1:0] d);
    tk.push_back(k);
    td.push_back(d);
  endtask

  // Reference: evaluate the token list as an RPN expression on a bounded stack.
  task automatic prepare();
    logic [N-1:0] vals[$];
    logic [N-1:0] a, b, r;
    logic o, err, ovf, done;
    err = 0; ovf = 0; done = 0;
    e_r = '0;
    foreach (tk[i]) begin
      if (done) begin
      end else if (err) begin
        if (tk[i] == 2'b11) done = 1;
      end else if (tk[i] == 2'b00) begin
        if (vals.size() == SD) err = 1;
        else begin
          vals.push_back(td[i]);
          exp_q.push_back({3'b110, td[i]});
        end
      end else if (tk[i] != 2'b11) begin
        if (vals.size() < 2) err = 1;
        else begin
          b = vals.pop_back();
          a = vals.pop_back();
          arith(tk[i], a, b, r, o);
          vals.push_back(r);
          ovf = ovf | o;
          exp_q.push_back({(tk[i] == 2'b01) ? 3'b100 : 3'b101, {N{1'b0}}});
        end
      end else begin
        done = 1;
        if (vals.size() != 1) err = 1;
        else begin
          exp_q.push_back({3'b111, {N{1'b0}}});
          e_r = vals[0];
        end
      end
    end
    e_ro = ovf;
    e_re = err;
    if (err) begin
      repeat (vals.size()) exp_q.push_back({3'b111, {N{1'b0}}});
      e_r   = '0;
      e_lat = vals.size() + 2;
    end else begin
      e_lat = 3;
    end
  endtask

  task automatic run_expr(input int hold, input int first);
    int cnt;
    for (int i = first; i < tk.size(); i++) send_tok(tk[i], td[i]);
    cnt = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (s_res_valid) begin
        cnt = i;
        break;
      end
    end
    check("res_latency", cnt, e_lat);
    check("res_data", s_res_data, e_r);
    check("res_overflow", s_res_ovf, e_ro);
    check("res_error", s_res_err, e_re);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_res_valid", s_res_valid, 1);
      check("hold_res_data", s_res_data, e_r);
      check("hold_tok_ready", s_tok_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("alu_trace_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int d, len;
    logic [1:0] k;
    RST       = 1'b1;
    tok_valid = 1'b0;
    tok_kind  = 2'b00;
    tok_data  = '0;
    res_ready = 1'b0;
    tick();
    check("rst_tok_ready", s_tok_ready, 0);
    RST = 1'b0;
    tick();
    check("reset_tok_ready", s_tok_ready, 1);
    check("reset_opcode", s_op, 0);
    check("reset_alu_data", s_data, 0);
    check("reset_res_valid", s_res_valid, 0);
    check("reset_res", {s_res_data, s_res_ovf, s_res_err}, 0);
    check("reset_depth", s_depth, 0);

    // 3 4 + 5 * end = 35
    clear_toks();
    add_tok(0, 3); add_tok(0, 4); add_tok(1, 0); add_tok(0, 5); add_tok(2, 0); add_tok(3, 0);
    prepare();
    run_expr(0, 0);

    // single operand timing
    clear_toks();
    add_tok(0, 7); add_tok(3, 0);
    prepare();
    send_tok(0, 7);
    tick();
    check("push_opcode", s_op, 3'b110);
    check("push_data", s_data, 7);
    check("push_tok_ready", s_tok_ready, 0);
    tick();
    check("push_tok_ready_back", s_tok_ready, 1);
    run_expr(0, 1);

    // signed overflow on add
    clear_toks();
    add_tok(0, 32'h7FFF_FFFF); add_tok(0, 1); add_tok(1, 0); add_tok(3, 0);
    prepare();
    run_expr(0, 0);

    // early error, then a clean expression
    clear_toks();
    add_tok(0, 5); add_tok(1, 0); add_tok(0, 2); add_tok(2, 0); add_tok(3, 0);
    prepare();
    run_expr(0, 0);
    clear_toks();
    add_tok(0, 2); add_tok(0, 2); add_tok(2, 0); add_tok(3, 0);
    prepare();
    run_expr(0, 0);

    // stack overflow: nine operands
    clear_toks();
    for (int i = 1; i <= 9; i++) add_tok(0, N'(i));
    add_tok(3, 0);
    prepare();
    run_expr(0, 0);

    // held result with back-pressure
    clear_toks();
    add_tok(0, 6); add_tok(0, 9); add_tok(2, 0); add_tok(3, 0);
    prepare();
    run_expr(5, 0);

    // reset while the push is being issued
    clear_toks();
    add_tok(0, 9);
    prepare();
    send_tok(0, 9);
    RST = 1'b1;
    tick();
    check("rst_exec_tok_ready", s_tok_ready, 0);
    RST = 1'b0;
    tick();
    check("post_rst_opcode", s_op, 0);
    check("post_rst_depth", s_depth, 0);
    check("post_rst_tok_ready", s_tok_ready, 1);
    check("post_rst_trace", exp_q.size(), 0);
    clear_toks();
    add_tok(0, 2); add_tok(0, 2); add_tok(2, 0); add_tok(3, 0);
    prepare();
    run_expr(0, 0);

    // random expressions, mostly well-formed
    for (int r = 0; r < 40; r++) begin
      clear_toks();
      d   = 0;
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        if (d < 2) k = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
        else k = 2'($urandom_range(0, 2));
        add_tok(k, ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 20)));
        d = (k == 2'b00) ? d + 1 : ((d > 0) ? d - 1 : 0);
      end
      while (d > 1 && $urandom_range(0, 4) != 0) begin
        add_tok(2'($urandom_range(1, 2)), 0);
        d--;
      end
      add_tok(3, 0);
      prepare();
      run_expr($urandom_range(0, 3), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
